// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle adder/subtractor processing DIGIT bits per clock, LSB digit first,
// with start/done handshake and carry/overflow/zero flags.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH % DIGIT != 0) begin : g_chk
    $error("digit_serial_adder: DIGIT must divide WIDTH exactly");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_d, s_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q, done_q, c_q, v_q, z_q;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   ch;
  // one digit slice: ripple chain of full-adder cells seeded by the stored carry
  always_comb begin
    ch    = '0;
    dsum  = '0;
    ch[0] = cy_q;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_q[i] ^ b_q[i] ^ ch[i];
      ch[i+1]  = (a_q[i] & b_q[i]) | (ch[i] & (a_q[i] ^ b_q[i]));
    end
    r_d = WIDTH'({dsum, r_q} >> DIGIT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= sub ? ~b : b;
          cy_q    <= sub;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          r_q   <= r_d;
          cy_q  <= ch[DIGIT];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            s_q     <= r_d;
            c_q     <= ch[DIGIT];
            v_q     <= ch[DIGIT] ^ ch[DIGIT-1];
            z_q     <= ~|r_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign s    = s_q;
  assign c    = c_q;
  assign v    = v_q;
  assign z    = z_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: scoreboard bench for the 32/4 adder plus 8-bit sweeps with DIGIT 1, 2, 8.
module tb_digit_serial_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b0, rst8 = 1'b1;
  logic        start = 1'b0, sb32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, s32;
  logic        bz, dn, c32, v32, z32;
  logic [34:0] q32[$];
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sb32), .a(a32), .b(b32),
    .busy(bz), .done(dn), .s(s32), .c(c32), .v(v32), .z(z32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: {s, c, v, z} for a w-bit add/sub using plain integer arithmetic
  function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y, input logic m);
    longint unsigned msk = (64'd1 << w) - 1;
    longint unsigned r, full;
    logic sx, sy, sr, cf, vf;
    full = m ? ({32'd0, x} - {32'd0, y}) : ({32'd0, x} + {32'd0, y});
    r  = full & msk;
    cf = m ? (x >= y) : (full > msk);
    sx = x[w-1];
    sy = y[w-1];
    sr = r[w-1];
    vf = m ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
    return {r[31:0], cf, vf, r == 0};
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic m);
    @(negedge clk);
    a32 = x; b32 = y; sb32 = m; start = 1'b1;
    q32.push_back(model(32, x, y, m));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_op(input string t);
    int cyc = 0, bc = 0;
    while (!dn && cyc < 40) begin
      bc += int'(bz);
      @(posedge clk);
      #1 cyc++;
    end
    check({t, "_lat"}, 64'(cyc), 64'd8);
    check({t, "_busy"}, 64'(bc), 64'd8);
    if (q32.size() == 0) check({t, "_sb_empty"}, 64'd1, 64'd0);
    else check({t, "_res"}, {29'd0, s32, c32, v32, z32}, {29'd0, q32.pop_front()});
    @(posedge clk);
    #1 check({t, "_pulse"}, {62'd0, dn, bz}, 64'd0);
  endtask

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int D = g == 0 ? 1 : (g == 1 ? 2 : 8);
    localparam int N = 8 / D;
    logic        st = 1'b0, sb = 1'b0, bzo, dno, co, vo, zo;
    logic [7:0]  ai = '0, bi = '0, so;
    logic [34:0] q[$];
    bit          fin = 1'b0;
    digit_serial_adder #(.WIDTH(8), .DIGIT(D)) u (
      .clk(clk), .rst(rst8), .start(st), .sub(sb), .a(ai), .b(bi),
      .busy(bzo), .done(dno), .s(so), .c(co), .v(vo), .z(zo)
    );
    // start held high: accept edges are expected exactly N+2 cycles apart
    initial begin
      wait (!rst8);
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        ai = 8'($urandom); bi = 8'($urandom); sb = 1'($urandom); st = 1'b1;
        q.push_back(model(8, {24'd0, ai}, {24'd0, bi}, sb));
        @(posedge clk);
        if (i < 999) repeat (N + 1) @(posedge clk);
        @(negedge clk);
      end
      st = 1'b0;
    end
    initial begin
      int got, cyc, last;
      got = 0; cyc = 0; last = 0;
      wait (!rst8);
      while (got < 1000 && cyc < 1000 * (N + 2) + 100) begin
        @(posedge clk);
        #1 cyc++;
        if (dno) begin
          if (q.size() == 0) check($sformatf("sweep%0d_extra", D), 64'd1, 64'd0);
          else check($sformatf("sweep%0d_res", D), {29'd0, 24'd0, so, co, vo, zo}, {29'd0, q.pop_front()});
          if (got > 0) check($sformatf("sweep%0d_gap", D), 64'(cyc - last), 64'(N + 2));
          last = cyc;
          got++;
        end
      end
      check($sformatf("sweep%0d_count", D), 64'(got), 64'd1000);
      fin = 1'b1;
    end
  end

  initial #22 rst8 = 1'b0;

  initial begin
    int nd;
    logic acc;
    #2 rst = 1'b1;
    #1 check("por", {26'd0, bz, dn, s32, c32, v32, z32}, 64'd0);
    @(negedge clk) rst = 1'b0;
    acc = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1 acc = acc | dn | bz;
    end
    check("idle", 64'(acc), 64'd0);
    drive(32'h00000001, 32'hFFFFFFFF, 1'b0);
    finish_op("wrap");
    check("wrap_flags", {32'd0, s32, c32, v32, z32}, {32'd0, 32'h0, 3'b101});
    drive(32'h7FFFFFFF, 32'h00000001, 1'b0);
    finish_op("ovf");
    drive(32'd5, 32'd7, 1'b1);
    finish_op("sub57");
    drive(32'h80000000, 32'd1, 1'b1);
    finish_op("subovf");
    drive(32'd1, 32'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a32 = 32'd3; b32 = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    a32 = 32'hDEAD; b32 = 32'hBEEF; sb32 = 1'b1;
    nd = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (dn) begin
        nd++;
        if (q32.size() == 0) check("drop_extra", 64'd1, 64'd0);
        else check("drop_res", {29'd0, s32, c32, v32, z32}, {29'd0, q32.pop_front()});
      end
    end
    check("drop_cnt", 64'(nd), 64'd1);
    drive(32'd1, 32'd1, 1'b0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_run", {26'd0, bz, dn, s32, c32, v32, z32}, 64'd0);
    q32.delete();
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1 nd += int'(dn);
    end
    check("rst_nodone", 64'(nd), 64'd0);
    drive(32'd10, 32'd20, 1'b0);
    finish_op("after_rst");
    check("after_rst_s", {32'd0, s32}, 64'd30);
    wait (sw[0].fin && sw[1].fin && sw[2].fin);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
